// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_e;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_I    = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

   // Owner code reported for a given arbiter state
   function automatic logic [1:0] owner_of(arb_state_e s);
      case (s)
         ARB_GRANT_I: owner_of = OWN_I;
         ARB_GRANT_D: owner_of = OWN_D;
         default:     owner_of = OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// rtl/mem_arb_wait_cnt.sv - saturating I-request starvation counter
module mem_arb_wait_cnt #(
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt;

   assign sat = (cnt >= CNT_W'(MAX_WAIT));

   // Clear has priority over increment; count stops at MAX_WAIT
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for the shared off-chip memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] i_mem_rdata,
   output logic              i_mem_ready,
   input  logic              d_mem_read,
   input  logic              d_mem_write,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wdata,
   output logic [DATA_W-1:0] d_mem_rdata,
   output logic              d_mem_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [1:0]        owner
);

   arb_state_e        state, state_nxt;
   logic              rd_nxt, wr_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic              req_i, req_d;
   logic              wait_sat, wait_inc, wait_clr;

   assign req_i = i_mem_read | i_mem_write;
   assign req_d = d_mem_read | d_mem_write;

   // Starvation counter: counts while I waits, cleared on I grant or when I goes quiet
   assign wait_inc = req_i && (state != ARB_GRANT_I);
   assign wait_clr = !req_i || ((state == ARB_IDLE) && (state_nxt == ARB_GRANT_I));

   mem_arb_wait_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .inc (wait_inc),
      .clr (wait_clr),
      .sat (wait_sat)
   );

   // Ready is routed only to the current owner and never while in reset
   assign i_mem_ready = mem_ready && (state == ARB_GRANT_I) && !rst;
   assign d_mem_ready = mem_ready && (state == ARB_GRANT_D) && !rst;
   assign i_mem_rdata = mem_rdata;
   assign d_mem_rdata = mem_rdata;

   // Next-state and next memory-port values; D wins ties unless I has waited long enough
   always_comb begin
      state_nxt = state;
      rd_nxt    = mem_read;
      wr_nxt    = mem_write;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      case (state)
         ARB_IDLE: begin
            if (req_i && (!req_d || wait_sat)) begin
               state_nxt = ARB_GRANT_I;
               addr_nxt  = i_mem_addr;
               wdata_nxt = i_mem_wdata;
               wr_nxt    = i_mem_write;
               rd_nxt    = i_mem_read & ~i_mem_write;
            end else if (req_d) begin
               state_nxt = ARB_GRANT_D;
               addr_nxt  = d_mem_addr;
               wdata_nxt = d_mem_wdata;
               wr_nxt    = d_mem_write;
               rd_nxt    = d_mem_read & ~d_mem_write;
            end
         end
         ARB_GRANT_I, ARB_GRANT_D: begin
            if (mem_ready) begin
               state_nxt = ARB_RELEASE;
               rd_nxt    = 1'b0;
               wr_nxt    = 1'b0;
            end
         end
         ARB_RELEASE: begin
            state_nxt = ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State and registered memory-port / owner outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= OWN_NONE;
      end else begin
         state     <= state_nxt;
         mem_read  <= rd_nxt;
         mem_write <= wr_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         owner     <= owner_of(state_nxt);
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = 8;

   logic          clk;
   logic          rst;
   logic          i_mem_read, i_mem_write;
   logic [AW-1:0] i_mem_addr;
   logic [DW-1:0] i_mem_wdata, i_mem_rdata;
   logic          i_mem_ready;
   logic          d_mem_read, d_mem_write;
   logic [AW-1:0] d_mem_addr;
   logic [DW-1:0] d_mem_wdata, d_mem_rdata;
   logic          d_mem_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;
   logic [1:0]    owner;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
      .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
      .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Both strobes from one cache at once is illegal stimulus
   always @(posedge clk) begin
      assert (!(d_mem_read && d_mem_write)) else $error("illegal D read+write request");
      assert (!(i_mem_read && i_mem_write)) else $error("illegal I read+write request");
   end

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: who holds the port (0 none, 1 I, 2 D), a one-cycle release gap,
   // the I waiting time, and what the memory port should be showing.
   int            m_own;
   bit            m_rel;
   int            m_wait;
   logic          m_rd, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;

   task automatic model_clear();
      m_own = 0; m_rel = 0; m_wait = 0;
      m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
   endtask

   task automatic model_update();
      bit ri, rq;
      int w, win;
      if (rst) begin
         model_clear();
         return;
      end
      ri = i_mem_read | i_mem_write;
      rq = d_mem_read | d_mem_write;
      if (!ri) w = 0;
      else if (m_own != 1) w = (m_wait + 1 > MW) ? MW : m_wait + 1;
      else w = m_wait;
      if (m_rel) begin
         m_rel = 0;
      end else if (m_own != 0) begin
         if (mem_ready) begin
            m_own = 0; m_rel = 1; m_rd = 0; m_wr = 0;
         end
      end else begin
         win = 0;
         if (ri && (!rq || m_wait >= MW)) win = 1;
         else if (rq) win = 2;
         if (win == 1) begin
            m_addr = i_mem_addr; m_wdata = i_mem_wdata;
            m_wr = i_mem_write; m_rd = i_mem_read & ~i_mem_write;
            w = 0;
         end else if (win == 2) begin
            m_addr = d_mem_addr; m_wdata = d_mem_wdata;
            m_wr = d_mem_write; m_rd = d_mem_read & ~d_mem_write;
         end
         m_own = win;
      end
      m_wait = w;
   endtask

   bit exp_ir, exp_dr;

   task automatic check_regs();
      logic [1:0] eo;
      eo = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      check_eq("mem_read", mem_read, m_rd);
      check_eq("mem_write", mem_write, m_wr);
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("mem_wdata", mem_wdata, m_wdata);
      check_eq("owner", owner, eo);
   endtask

   task automatic settle_check();
      #1;
      exp_ir = mem_ready && !rst && (m_own == 1);
      exp_dr = mem_ready && !rst && (m_own == 2);
      check_eq("i_mem_ready", i_mem_ready, exp_ir);
      check_eq("d_mem_ready", d_mem_ready, exp_dr);
      check_eq("i_mem_rdata", i_mem_rdata, mem_rdata);
      check_eq("d_mem_rdata", d_mem_rdata, mem_rdata);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_regs();
   endtask

   task automatic cycle();
      settle_check();
      tick();
   endtask

   task automatic idle_inputs();
      i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
      mem_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs();
      cycle();
      rst = 0;
   endtask

   // Random cache and memory behaviour
   bit i_act, d_act, i_got, d_got, prev_rdy;
   int lat, tgt;

   task automatic drive_random(input int p_i, input int p_d);
      if (i_got) begin
         i_mem_read = 0; i_mem_write = 0; i_act = 0; i_got = 0;
      end else if (!i_act && ($urandom_range(99) < p_i)) begin
         i_act = 1;
         i_mem_write = ($urandom_range(19) == 0);
         i_mem_read = ~i_mem_write;
         i_mem_addr = AW'($urandom);
         i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (d_got) begin
         d_mem_read = 0; d_mem_write = 0; d_act = 0; d_got = 0;
      end else if (!d_act && ($urandom_range(99) < p_d)) begin
         d_act = 1;
         d_mem_write = $urandom_range(1);
         d_mem_read = ~d_mem_write;
         d_mem_addr = AW'($urandom);
         d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_ready = 0;
      if (rst) begin
         lat = 0;
         mem_ready = ($urandom_range(3) == 0);
      end else if ((mem_read || mem_write) && !prev_rdy) begin
         lat++;
         if (lat >= tgt) begin
            mem_ready = 1; lat = 0; tgt = $urandom_range(5, 1);
         end
      end else if (!(mem_read || mem_write) && ($urandom_range(7) == 0)) begin
         mem_ready = 1;
      end
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      prev_rdy = mem_ready;
   endtask

   task automatic run_random(input int n, input int p_i, input int p_d);
      for (int k = 0; k < n; k++) begin
         if (!rst && $urandom_range(299) == 0) rst = 1;
         else if (rst && $urandom_range(1) == 0) rst = 0;
         drive_random(p_i, p_d);
         settle_check();
         if (exp_ir) i_got = 1;
         if (exp_dr) d_got = 1;
         tick();
      end
   endtask

   initial begin
      rst = 1; idle_inputs();
      i_mem_addr = '0; i_mem_wdata = '0; d_mem_addr = '0; d_mem_wdata = '0;
      mem_rdata = '0;
      model_clear();
      i_act = 0; d_act = 0; i_got = 0; d_got = 0; prev_rdy = 0; lat = 0; tgt = 3;

      // Reset held with both caches requesting
      i_mem_read = 1; i_mem_addr = 28'h30;
      d_mem_read = 1; d_mem_addr = 28'h50;
      cycle(); cycle();
      check_eq("rst_owner", owner, 2'b00);
      check_eq("rst_strobes", {mem_read, mem_write}, 2'b00);
      check_eq("rst_addr", mem_addr, 28'h0);
      rst = 0;
      cycle();
      check_eq("t1_first_strobe", mem_read, 1'b1);
      check_eq("t1_first_addr", mem_addr, 28'h50);
      do_reset();

      // Lone I read, memory answers after 5 cycles
      i_mem_read = 1; i_mem_addr = 28'h10;
      cycle();
      check_eq("t2_read", mem_read, 1'b1);
      check_eq("t2_addr", mem_addr, 28'h10);
      check_eq("t2_owner", owner, 2'b01);
      cycle(); cycle(); cycle(); cycle();
      mem_ready = 1; mem_rdata = 128'hDEADBEEF;
      settle_check();
      check_eq("t2_i_ready", i_mem_ready, 1'b1);
      check_eq("t2_i_rdata", i_mem_rdata, 128'hDEADBEEF);
      check_eq("t2_d_ready", d_mem_ready, 1'b0);
      tick();
      i_mem_read = 0; mem_ready = 0;
      cycle();
      cycle();

      // Simultaneous I read and D write: D first, I at ready+2
      i_mem_read = 1; i_mem_addr = 28'h20;
      d_mem_write = 1; d_mem_addr = 28'h40; d_mem_wdata = 128'h1234;
      cycle();
      check_eq("t3_d_write", mem_write, 1'b1);
      check_eq("t3_d_addr", mem_addr, 28'h40);
      check_eq("t3_d_wdata", mem_wdata, 128'h1234);
      cycle();
      mem_ready = 1;
      cycle();
      check_eq("t3_release_strobe", {mem_read, mem_write}, 2'b00);
      d_mem_write = 0; mem_ready = 0;
      cycle();
      check_eq("t3_idle_gap", mem_read, 1'b0);
      cycle();
      check_eq("t3_i_read", mem_read, 1'b1);
      check_eq("t3_i_addr", mem_addr, 28'h20);
      do_reset();

      // Reset two cycles into a D grant
      d_mem_write = 1; d_mem_addr = 28'h77;
      cycle(); cycle(); cycle();
      rst = 1;
      cycle();
      check_eq("t5_write_cleared", mem_write, 1'b0);
      rst = 0; d_mem_write = 0;
      cycle();
      mem_ready = 1;
      settle_check();
      check_eq("t5_no_fwd", d_mem_ready, 1'b0);
      tick();
      check_eq("t5_owner", owner, 2'b00);
      mem_ready = 0;
      cycle();

      // Random traffic with spurious readies and occasional resets, then heavy contention
      run_random(3000, 35, 35);
      run_random(1500, 100, 100);
      rst = 0;
      run_random(1500, 60, 90);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
